s5_tsd_sequencer: RTL



---
 rtl/s5_tsd_pkg.sv | 9 +
 rtl/s5_tsd_clk_div.sv | 26 ++
 rtl/s5_tsd_sequencer.sv | 111 +++++++++++
 3 files changed

// File: rtl/s5_tsd_pkg.sv
// s5_tsd_pkg: shared state type, constants and saturation helper for the TSD sequencer
package s5_tsd_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_CONVERT, S_HOLDOFF} tsd_state_e;
  localparam int DEF_OFFSET = 133;
  localparam logic [7:0] BAD_CODE = 8'hFF;
  function automatic logic [7:0] sat8(input logic signed [9:0] v);
    return (v > 10'sd127) ? 8'h7F : (v < -10'sd128) ? 8'h80 : v[7:0];
  endfunction
endpackage

// File: rtl/s5_tsd_clk_div.sv
// s5_tsd_clk_div: divides clk into tsd_clk and flags the cycle before each tsd_clk edge
module s5_tsd_clk_div #(
  parameter int HALF_DIV = 2048
) (
  input  logic clk,
  input  logic rst_n,
  output logic tsd_clk,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(HALF_DIV);
  logic [CW-1:0] cnt;
  logic wrap;
  assign wrap = cnt == CW'(HALF_DIV - 1);
  assign rise = wrap & ~tsd_clk;
  assign fall = wrap & tsd_clk;
  // half-period counter; tsd_clk toggles on the edge that ends a strobe cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      tsd_clk <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      tsd_clk <= tsd_clk ^ wrap;
    end
endmodule

// File: rtl/s5_tsd_sequencer.sv
// s5_tsd_sequencer: drives the tsdblock ADC, screens samples and reports degrees C
module s5_tsd_sequencer import s5_tsd_pkg::*; #(
  parameter int HALF_DIV  = 2048,
  parameter int CLR_TICKS = 2,
  parameter int TIMEOUT   = 255,
  parameter int HOLDOFF   = 16,
  parameter int OFFSET    = DEF_OFFSET,
  parameter int ALARM_HI  = 85,
  parameter int ALARM_LO  = 80
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic       tsd_clk,
  output logic       tsd_ce,
  output logic       tsd_clr,
  input  logic [7:0] tsd_out,
  input  logic       tsd_done,
  output logic [7:0] temp_c,
  output logic       temp_valid,
  output logic       over_temp,
  output logic       sample_err,
  output logic [7:0] err_count
);
  localparam int TW = 16;
  localparam logic signed [7:0] HI8 = 8'(ALARM_HI);
  localparam logic signed [7:0] LO8 = 8'(ALARM_LO);
  logic rise, fall, conv_fall, good, bad;
  logic [1:0] pol;
  logic [TW-1:0] tick, tick_nx;
  logic signed [9:0] diff;
  logic [7:0] temp_nx;
  tsd_state_e state, state_nx;
  s5_tsd_clk_div #(.HALF_DIV(HALF_DIV)) u_div (
    .clk(clk),
    .rst_n(rst_n),
    .tsd_clk(tsd_clk),
    .rise(rise),
    .fall(fall)
  );
  assign conv_fall = fall & (state == S_CONVERT);
  assign good = conv_fall & tsd_done & (tsd_out != BAD_CODE);
  assign bad = conv_fall & ~good & (tsd_done | (tick >= TW'(TIMEOUT)));
  assign diff = $signed({2'b00, tsd_out}) - $signed(10'(OFFSET));
  assign temp_nx = sat8(diff);
  // next state: sample verdicts come on fall, all other moves on rise
  always_comb begin
    state_nx = state;
    tick_nx = tick;
    if (good | bad) begin
      state_nx = S_HOLDOFF;
      tick_nx = '0;
    end else if (rise) begin
      case (state)
        S_IDLE: if (enable) begin
          state_nx = S_CLEAR;
          tick_nx = '0;
        end
        S_CLEAR: begin
          state_nx = (tick == TW'(CLR_TICKS - 1)) ? S_CONVERT : S_CLEAR;
          tick_nx = (tick == TW'(CLR_TICKS - 1)) ? '0 : tick + 1'b1;
        end
        S_CONVERT: tick_nx = (tick == '1) ? tick : tick + 1'b1;
        S_HOLDOFF: begin
          state_nx = (tick == TW'(HOLDOFF - 1)) ? S_IDLE : S_HOLDOFF;
          tick_nx = (tick == TW'(HOLDOFF - 1)) ? '0 : tick + 1'b1;
        end
      endcase
    end
  end
  // FSM state and tick counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      tick <= '0;
    end else begin
      state <= state_nx;
      tick <= tick_nx;
    end
  // ADC controls move only with the tsd_clk rising edge, picking up any new polarity
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tsd_clr <= 1'b0;
      tsd_ce <= 1'b0;
    end else if (rise) begin
      tsd_clr <= (state_nx == S_CLEAR) ^ pol[0];
      tsd_ce <= pol[1];
    end
  // sample results, alarm hysteresis, error tracking and polarity adaptation
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      temp_c <= '0;
      temp_valid <= 1'b0;
      over_temp <= 1'b0;
      sample_err <= 1'b0;
      err_count <= '0;
      pol <= '0;
    end else begin
      temp_valid <= good;
      if (good) begin
        temp_c <= temp_nx;
        over_temp <= ($signed(temp_nx) >= HI8) ? 1'b1 : ($signed(temp_nx) <= LO8) ? 1'b0 : over_temp;
        sample_err <= 1'b0;
      end
      if (bad) begin
        sample_err <= 1'b1;
        err_count <= err_count + {7'd0, err_count != 8'hFF};
        pol <= pol + 2'd1;
      end
    end
endmodule
